// File: rtl/cnn_weight_streamer.sv
// Streams one contiguous weight image from a synchronous-read memory onto five
// per-conv channels; words are tagged with their segment and emitted 2 cycles after issue.
module cnn_weight_streamer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int BASE_ADDR  = 0,
  parameter int LEN1       = 4096,
  parameter int LEN2       = 36864,
  parameter int LEN3       = 16384,
  parameter int LEN4       = 16384,
  parameter int LEN5       = 16384
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  hold,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  valid_weight_out1,
  output logic                  valid_weight_out2,
  output logic                  valid_weight_out3,
  output logic                  valid_weight_out4,
  output logic                  valid_weight_out5,
  output logic [DATA_WIDTH-1:0] weight_out1,
  output logic [DATA_WIDTH-1:0] weight_out2,
  output logic [DATA_WIDTH-1:0] weight_out3,
  output logic [DATA_WIDTH-1:0] weight_out4,
  output logic [DATA_WIDTH-1:0] weight_out5,
  output logic                  busy,
  output logic                  done
);

  function automatic int max_len();
    int m;
    m = LEN1;
    if (LEN2 > m) m = LEN2;
    if (LEN3 > m) m = LEN3;
    if (LEN4 > m) m = LEN4;
    if (LEN5 > m) m = LEN5;
    return m;
  endfunction

  localparam int CNT_W = $clog2(max_len()) + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [2:0]            seg_q;
  logic [2:0]            tag_p1_q;
  logic [4:0]            vld_p2_q;
  logic [DATA_WIDTH-1:0] data_p2_q;
  logic                  issue;

  function automatic logic [CNT_W-1:0] seg_last(input logic [2:0] seg);
    case (seg)
      3'd1:    seg_last = CNT_W'(LEN1 - 1);
      3'd2:    seg_last = CNT_W'(LEN2 - 1);
      3'd3:    seg_last = CNT_W'(LEN3 - 1);
      3'd4:    seg_last = CNT_W'(LEN4 - 1);
      default: seg_last = CNT_W'(LEN5 - 1);
    endcase
  endfunction

  function automatic logic [4:0] tag_onehot(input logic [2:0] tag);
    case (tag)
      3'd1:    tag_onehot = 5'b00001;
      3'd2:    tag_onehot = 5'b00010;
      3'd3:    tag_onehot = 5'b00100;
      3'd4:    tag_onehot = 5'b01000;
      3'd5:    tag_onehot = 5'b10000;
      default: tag_onehot = 5'b00000;
    endcase
  endfunction

  // hold gates the issue in the same cycle, so mem_en is a decode rather than a register
  assign issue    = (state_q == S_READ) && !hold;
  assign mem_en   = issue;
  assign mem_addr = addr_q;
  assign busy     = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done     = (state_q == S_FIN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      seg_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_READ;
            addr_q  <= ADDR_WIDTH'(BASE_ADDR);
            cnt_q   <= '0;
            seg_q   <= 3'd1;
          end
        end
        S_READ: begin
          if (!hold) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            if (cnt_q == seg_last(seg_q)) begin
              cnt_q <= '0;
              if (seg_q == 3'd5) state_q <= S_DRAIN;
              else               seg_q   <= seg_q + 3'd1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (tag_p1_q == 3'd0) state_q <= S_FIN;
        end
        S_FIN: state_q <= S_IDLE;
      endcase
    end
  end

  // p1: tag rides alongside the memory read; p2: capture read data and steer the valid
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_p1_q  <= '0;
      vld_p2_q  <= '0;
      data_p2_q <= '0;
    end else begin
      tag_p1_q <= issue ? seg_q : 3'd0;
      vld_p2_q <= tag_onehot(tag_p1_q);
      if (tag_p1_q != 3'd0) data_p2_q <= mem_rdata;
    end
  end

  assign valid_weight_out1 = vld_p2_q[0];
  assign valid_weight_out2 = vld_p2_q[1];
  assign valid_weight_out3 = vld_p2_q[2];
  assign valid_weight_out4 = vld_p2_q[3];
  assign valid_weight_out5 = vld_p2_q[4];
  assign weight_out1       = data_p2_q;
  assign weight_out2       = data_p2_q;
  assign weight_out3       = data_p2_q;
  assign weight_out4       = data_p2_q;
  assign weight_out5       = data_p2_q;

endmodule

// File: tb/tb_cnn_weight_streamer.sv
// Bench for cnn_weight_streamer: small segment lengths, directed scenarios, and an
// issue-schedule model compared against the DUT every cycle.
module tb_cnn_weight_streamer;

  localparam int DW   = 32;
  localparam int AW   = 20;
  localparam int BASE = 'h10;
  localparam int NW   = 9;
  localparam int MAXR = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          v1, v2, v3, v4, v5;
  logic [DW-1:0] w1, w2, w3, w4, w5;
  logic          busy, done;

  cnn_weight_streamer #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
    .LEN1(2), .LEN2(3), .LEN3(1), .LEN4(1), .LEN5(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .valid_weight_out1(v1), .valid_weight_out2(v2), .valid_weight_out3(v3),
    .valid_weight_out4(v4), .valid_weight_out5(v5),
    .weight_out1(w1), .weight_out2(w2), .weight_out3(w3),
    .weight_out4(w4), .weight_out5(w5),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // synchronous-read memory: data appears the cycle after mem_en
  always @(posedge clk) if (mem_en) mem_rdata <= 32'h1000 + 32'(mem_addr);

  int total = 0;
  int bad   = 0;
  int scen  = 0;
  int rc    = 0;
  int done_cnt = 0;
  bit checking = 1'b0;

  int lens[5] = '{2, 3, 1, 1, 2};

  bit          st_a[MAXR];
  bit          hd_a[MAXR];
  bit          rs_a[MAXR];
  bit          e_en[MAXR];
  logic [31:0] e_addr[MAXR];
  bit          e_addr_chk[MAXR];
  logic [4:0]  e_vld[MAXR];
  logic [31:0] e_word[MAXR];
  logic [31:0] e_data[MAXR];
  bit          e_busy[MAXR];
  bit          e_done[MAXR];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s scen=%0d cyc=%0d got=%h want=%h", name, scen, rc, act, exp);
    end
  endtask

  function automatic int seg_of(input int w);
    int acc = 0;
    for (int n = 0; n < 5; n++) begin
      acc += lens[n];
      if (w < acc) return n;
    end
    return 4;
  endfunction

  task automatic clear_stim();
    for (int r = 0; r < MAXR; r++) begin
      st_a[r] = 0; hd_a[r] = 0; rs_a[r] = 0;
    end
  endtask

  // Words are issued on successive non-hold cycles after an accepted start and
  // appear 2 cycles later; a reset cancels everything after the reset cycle.
  task automatic build_model(input int R);
    int idle_from, c, L, x;
    logic [31:0] last;
    for (int r = 0; r < MAXR; r++) begin
      e_en[r] = 0; e_addr[r] = '0; e_addr_chk[r] = 0; e_vld[r] = '0;
      e_word[r] = '0; e_data[r] = '0; e_busy[r] = 0; e_done[r] = 0;
    end
    e_addr_chk[0] = 1;
    for (int t = 0; t + 1 < MAXR; t++) if (rs_a[t]) e_addr_chk[t+1] = 1;
    idle_from = 0;
    for (int s = 0; s < R; s++) begin
      if (st_a[s] && !rs_a[s] && s >= idle_from) begin
        x = MAXR + 10;
        for (int t = MAXR - 1; t > s; t--) if (rs_a[t]) x = t;
        c = s;
        L = s;
        for (int w = 0; w < NW; w++) begin
          c++;
          while (c < MAXR && hd_a[c]) c++;
          L = c;
          if (c <= x && c < MAXR) begin
            e_en[c] = 1; e_addr[c] = BASE + w; e_addr_chk[c] = 1;
          end
          if (c + 2 <= x && c + 2 < MAXR) begin
            e_vld[c+2]  = 5'(1 << seg_of(w));
            e_word[c+2] = 32'h1000 + BASE + w;
          end
        end
        for (int t = s + 1; t <= L + 2 && t <= x && t < MAXR; t++) e_busy[t] = 1;
        if (L + 3 <= x && L + 3 < MAXR) e_done[L+3] = 1;
        idle_from = (x <= L + 3) ? x + 1 : L + 4;
      end
    end
    last = '0;
    for (int r = 0; r < MAXR; r++) begin
      if (r > 0 && rs_a[r-1]) last = '0;
      if (e_vld[r] != 5'd0) last = e_word[r];
      e_data[r] = last;
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    if (checking) begin
      chk("mem_en", 32'(mem_en), 32'(e_en[rc]));
      if (e_addr_chk[rc]) chk("mem_addr", 32'(mem_addr), e_addr[rc]);
      chk("valids", 32'({v5, v4, v3, v2, v1}), 32'(e_vld[rc]));
      chk("weight_out1", w1, e_data[rc]);
      chk("weight_out2", w2, e_data[rc]);
      chk("weight_out3", w3, e_data[rc]);
      chk("weight_out4", w4, e_data[rc]);
      chk("weight_out5", w5, e_data[rc]);
      chk("busy", 32'(busy), 32'(e_busy[rc]));
      chk("done", 32'(done), 32'(e_done[rc]));
      if (done) done_cnt++;
    end
  end

  task automatic run(input int id, input int R);
    scen = id;
    build_model(R);
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0; hold = 1'b0; checking = 1'b0;
    done_cnt = 0;
    for (int r = 0; r < R; r++) begin
      @(posedge clk); #1;
      reset = rs_a[r]; start = st_a[r]; hold = hd_a[r];
      rc = r;
      checking = 1'b1;
      if (r == 0) begin
        #1;
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_valids", 32'({v5, v4, v3, v2, v1}), 32'd0);
        chk("rst_weight", w3, 32'd0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
      end
    end
    @(posedge clk); #1;
    checking = 1'b0;
  endtask

  initial begin
    // basic stream
    clear_stim();
    st_a[0] = 1;
    build_model(16);
    chk("pin_en9", 32'(e_en[9]), 32'd1);
    chk("pin_addr9", e_addr[9], 32'h18);
    chk("pin_vld3", 32'(e_vld[3]), 32'h01);
    chk("pin_data4", e_data[4], 32'h1011);
    chk("pin_vld7", 32'(e_vld[7]), 32'h02);
    chk("pin_vld9", 32'(e_vld[9]), 32'h08);
    chk("pin_vld10", 32'(e_vld[10]), 32'h10);
    chk("pin_data11", e_data[11], 32'h1018);
    chk("pin_done12", 32'(e_done[12]), 32'd1);
    chk("pin_busy11", 32'(e_busy[11]), 32'd1);
    chk("pin_busy12", 32'(e_busy[12]), 32'd0);
    run(1, 16);
    chk("done_count_basic", 32'(done_cnt), 32'd1);

    // hold in cycles 3-4
    clear_stim();
    st_a[0] = 1; hd_a[3] = 1; hd_a[4] = 1;
    build_model(18);
    chk("pin_hold_en3", 32'(e_en[3]), 32'd0);
    chk("pin_hold_addr5", e_addr[5], 32'h12);
    chk("pin_hold_vld6", 32'(e_vld[6]), 32'd0);
    chk("pin_hold_done14", 32'(e_done[14]), 32'd1);
    run(2, 18);

    // second start while busy is ignored
    clear_stim();
    st_a[0] = 1; st_a[5] = 1;
    run(3, 18);
    chk("done_count_busy_start", 32'(done_cnt), 32'd1);

    // reset mid-stream, then restart
    clear_stim();
    st_a[0] = 1; rs_a[6] = 1; st_a[9] = 1;
    build_model(26);
    chk("pin_rst_busy7", 32'(e_busy[7]), 32'd0);
    chk("pin_rst_en10", 32'(e_en[10]), 32'd1);
    chk("pin_rst_addr10", e_addr[10], 32'h10);
    run(4, 26);
    chk("done_count_reset", 32'(done_cnt), 32'd1);

    // back-to-back start in the cycle after done
    clear_stim();
    st_a[0] = 1; st_a[13] = 1;
    build_model(30);
    chk("pin_b2b_addr14", e_addr[14], 32'h10);
    chk("pin_b2b_done25", 32'(e_done[25]), 32'd1);
    run(5, 30);
    chk("done_count_b2b", 32'(done_cnt), 32'd2);

    // hold in IDLE and DRAIN has no effect
    clear_stim();
    st_a[0] = 1; hd_a[0] = 1; hd_a[10] = 1; hd_a[11] = 1; hd_a[12] = 1;
    run(6, 16);
    chk("done_count_idle_hold", 32'(done_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
